// File: rtl/ll_disp_pkg.sv
// Shared types, glyph constants and BCD helpers for the lander display path.
package ll_disp_pkg;

  // Quantity selector, encoded as on the sel output.
  typedef enum logic [1:0] {
    SEL_ALT    = 2'd0,
    SEL_VEL    = 2'd1,
    SEL_FUEL   = 2'd2,
    SEL_THRUST = 2'd3
  } sel_e;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CONV   = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // Quantity glyphs shown on the leftmost digit.
  localparam logic [7:0] GLYPH_A     = 8'h77;
  localparam logic [7:0] GLYPH_U     = 8'h3E;
  localparam logic [7:0] GLYPH_F     = 8'h71;
  localparam logic [7:0] GLYPH_T     = 8'h78;
  localparam logic [7:0] GLYPH_MINUS = 8'h40;

  // Edges from capture to the committed display.
  localparam int DISP_LATENCY = 5;

  // Seven-segment pattern for one BCD digit; non-BCD codes show nothing.
  function automatic logic [7:0] digit_glyph(input logic [3:0] dig);
    logic [7:0] g;
    case (dig)
      4'd0:    g = 8'h3F;
      4'd1:    g = 8'h06;
      4'd2:    g = 8'h5B;
      4'd3:    g = 8'h4F;
      4'd4:    g = 8'h66;
      4'd5:    g = 8'h6D;
      4'd6:    g = 8'h7D;
      4'd7:    g = 8'h07;
      4'd8:    g = 8'h7F;
      4'd9:    g = 8'h67;
      default: g = 8'h00;
    endcase
    return g;
  endfunction

  // Glyph identifying the quantity on display.
  function automatic logic [7:0] sel_glyph(input sel_e s);
    logic [7:0] g;
    case (s)
      SEL_ALT:    g = GLYPH_A;
      SEL_VEL:    g = GLYPH_U;
      SEL_FUEL:   g = GLYPH_F;
      default:    g = GLYPH_T;
    endcase
    return g;
  endfunction

  // One digit of a ten's-complement negation: nine's complement plus carry in.
  // Returns {carry_out, digit}.
  function automatic logic [4:0] bcd_neg_digit(input logic [3:0] dig, input logic cin);
    logic [4:0] sum;
    sum = 5'd9 - {1'b0, dig} + {4'b0000, cin};
    if (sum >= 5'd10) begin
      return {1'b1, sum[3:0] - 4'd10};
    end
    return {1'b0, sum[3:0]};
  endfunction

endpackage

// File: rtl/ll_pb_sync.sv
// Pushbutton synchroniser chain followed by a history flop for rising-edge detect.
module ll_pb_sync #(
  parameter int WIDTH       = 4,
  parameter int SYNC_STAGES = 2   // at least 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pb_i,
  output logic [WIDTH-1:0] rise_o
);

  // chain_q holds all stages packed; the raw pins enter at the low end.
  logic [SYNC_STAGES*WIDTH-1:0] chain_q;
  logic [WIDTH-1:0]             hist_q;
  logic [WIDTH-1:0]             sync_w;

  assign sync_w = chain_q[SYNC_STAGES*WIDTH-1 -: WIDTH];
  assign rise_o = sync_w & ~hist_q;

  // Shift the raw buttons through the synchroniser and remember the last synced value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chain_q <= '0;
      hist_q  <= '0;
    end else begin
      chain_q <= {chain_q[(SYNC_STAGES-1)*WIDTH-1:0], pb_i};
      hist_q  <= sync_w;
    end
  end

endmodule

// File: rtl/ll_display.sv
// Samples one lander quantity, converts it to sign + magnitude digit by digit
// and commits all eight seven-segment outputs in a single cycle.
module ll_display
  import ll_disp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int SEL_RESET   = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wen,
  input  logic [15:0] alt,
  input  logic [15:0] vel,
  input  logic [15:0] fuel,
  input  logic [15:0] thrust,
  input  logic [3:0]  sel_pb,
  output logic        busy,
  output logic [1:0]  sel,
  output logic [7:0]  ss7,
  output logic [7:0]  ss6,
  output logic [7:0]  ss5,
  output logic [7:0]  ss4,
  output logic [7:0]  ss3,
  output logic [7:0]  ss2,
  output logic [7:0]  ss1,
  output logic [7:0]  ss0
);

  localparam sel_e SEL_INIT = sel_e'(2'(SEL_RESET));

  logic [3:0]       rise_w;
  logic [15:0]      src_w;
  logic             capture_w;
  logic             trigger_w;
  logic [3:0][7:0]  digit_seg_w;

  sel_e             sel_q, sel_d;
  sel_e             shown_q, shown_d;
  state_e           state_q, state_d;
  logic             pending_q, pending_d;
  logic [15:0]      work_q, work_d;
  logic             carry_q, carry_d;
  logic [1:0]       digit_q, digit_d;
  logic             neg_q, neg_d;
  logic             busy_q, busy_d;
  logic [7:0]       glyph_q, glyph_d;
  logic [7:0]       minus_q, minus_d;
  logic [3:0][7:0]  digits_q, digits_d;

  ll_pb_sync #(
    .WIDTH       (4),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pb_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .pb_i   (sel_pb),
    .rise_o (rise_w)
  );

  // Per-digit glyph with leading-zero blanking: a digit goes dark while it and
  // everything above it is zero. The units digit always shows.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      if (gi == 0) begin : g_units
        assign digit_seg_w[gi] = digit_glyph(work_q[3:0]);
      end else begin : g_upper
        assign digit_seg_w[gi] = (work_q[15:4*gi] == '0) ? 8'h00
                                                         : digit_glyph(work_q[4*gi +: 4]);
      end
    end
  endgenerate

  assign capture_w = (state_q == ST_IDLE) && pending_q;
  assign trigger_w = wen || (rise_w != 4'b0000);

  // Source mux for the quantity currently selected.
  always_comb begin
    src_w = alt;
    case (sel_q)
      SEL_ALT:    src_w = alt;
      SEL_VEL:    src_w = vel;
      SEL_FUEL:   src_w = fuel;
      default:    src_w = thrust;
    endcase
  end

  // Button selection with Z>Y>X>W priority, and the pending-trigger flag.
  always_comb begin
    sel_d = sel_q;
    if (rise_w[3])      sel_d = SEL_ALT;
    else if (rise_w[2]) sel_d = SEL_VEL;
    else if (rise_w[1]) sel_d = SEL_FUEL;
    else if (rise_w[0]) sel_d = SEL_THRUST;
    // A trigger arriving in the capture cycle must survive the capture.
    pending_d = trigger_w || (pending_q && !capture_w);
  end

  // Conversion sequencer: capture, four digit steps LSD first, then commit.
  always_comb begin
    state_d  = state_q;
    shown_d  = shown_q;
    work_d   = work_q;
    carry_d  = carry_q;
    digit_d  = digit_q;
    neg_d    = neg_q;
    busy_d   = busy_q;
    glyph_d  = glyph_q;
    minus_d  = minus_q;
    digits_d = digits_q;
    case (state_q)
      ST_IDLE: begin
        if (pending_q) begin
          work_d  = src_w;
          shown_d = sel_q;
          neg_d   = (sel_q == SEL_VEL) && (src_w[15:12] >= 4'd5);
          carry_d = 1'b1;
          digit_d = 2'd0;
          busy_d  = 1'b1;
          state_d = ST_CONV;
        end
      end
      ST_CONV: begin
        // Work rotates right one digit per step; after four steps every digit
        // is back in its own position, now holding the magnitude.
        if (neg_q) begin
          {carry_d, work_d[15:12]} = bcd_neg_digit(work_q[3:0], carry_q);
          work_d[11:0] = work_q[15:4];
        end else begin
          work_d = {work_q[3:0], work_q[15:4]};
        end
        digit_d = digit_q + 2'd1;
        if (digit_q == 2'd3) begin
          state_d = ST_COMMIT;
        end
      end
      ST_COMMIT: begin
        glyph_d  = sel_glyph(shown_q);
        minus_d  = neg_q ? GLYPH_MINUS : 8'h00;
        digits_d = digit_seg_w;
        busy_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset blanks the display and requests a first conversion.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel_q     <= SEL_INIT;
      shown_q   <= SEL_INIT;
      state_q   <= ST_IDLE;
      pending_q <= 1'b1;
      work_q    <= '0;
      carry_q   <= 1'b0;
      digit_q   <= 2'd0;
      neg_q     <= 1'b0;
      busy_q    <= 1'b0;
      glyph_q   <= '0;
      minus_q   <= '0;
      digits_q  <= '0;
    end else begin
      sel_q     <= sel_d;
      shown_q   <= shown_d;
      state_q   <= state_d;
      pending_q <= pending_d;
      work_q    <= work_d;
      carry_q   <= carry_d;
      digit_q   <= digit_d;
      neg_q     <= neg_d;
      busy_q    <= busy_d;
      glyph_q   <= glyph_d;
      minus_q   <= minus_d;
      digits_q  <= digits_d;
    end
  end

  assign busy = busy_q;
  assign sel  = sel_q;
  assign ss7  = glyph_q;
  assign ss6  = 8'h00;
  assign ss5  = 8'h00;
  assign ss4  = minus_q;
  assign ss3  = digits_q[3];
  assign ss2  = digits_q[2];
  assign ss1  = digits_q[1];
  assign ss0  = digits_q[0];

endmodule

// File: tb/tb_ll_display.sv
// Randomised scoreboard bench for ll_display: stimulus pushes the expected
// display and commit cycle, a monitor pops and compares at each commit.
module tb_ll_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wen = 1'b0;
  logic [15:0] alt = 16'h0000;
  logic [15:0] vel = 16'h0000;
  logic [15:0] fuel = 16'h0000;
  logic [15:0] thrust = 16'h0000;
  logic [3:0]  sel_pb = 4'b0000;
  logic        busy;
  logic [1:0]  sel;
  logic [7:0]  ss7, ss6, ss5, ss4, ss3, ss2, ss1, ss0;

  ll_display #(.SYNC_STAGES(2), .SEL_RESET(0)) dut (
    .clk(clk), .rst_n(rst_n), .wen(wen),
    .alt(alt), .vel(vel), .fuel(fuel), .thrust(thrust),
    .sel_pb(sel_pb), .busy(busy), .sel(sel),
    .ss7(ss7), .ss6(ss6), .ss5(ss5), .ss4(ss4),
    .ss3(ss3), .ss2(ss2), .ss1(ss1), .ss0(ss0)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [63:0] segs;
    int unsigned at;
  } exp_t;
  exp_t exp_q[$];

  int          m_sel = 0;
  logic [15:0] m_val [4];

  function automatic logic [7:0] dig_glyph(input int d);
    case (d)
      0: return 8'h3F; 1: return 8'h06; 2: return 8'h5B; 3: return 8'h4F;
      4: return 8'h66; 5: return 8'h6D; 6: return 8'h7D; 7: return 8'h07;
      8: return 8'h7F; default: return 8'h67;
    endcase
  endfunction

  function automatic logic [7:0] q_glyph(input int s);
    case (s)
      0: return 8'h77; 1: return 8'h3E; 2: return 8'h71; default: return 8'h78;
    endcase
  endfunction

  // Reference: decode to an integer, negate in ten's complement if needed,
  // then print decimal digits with leading zeros suppressed.
  function automatic logic [63:0] model(input int s, input logic [15:0] v);
    logic [7:0] r [8];
    int n, mag, p;
    bit neg;
    n = int'(v[15:12]) * 1000 + int'(v[11:8]) * 100 + int'(v[7:4]) * 10 + int'(v[3:0]);
    neg = (s == 1) && (n >= 5000);
    mag = neg ? 10000 - n : n;
    r[7] = q_glyph(s);
    r[6] = 8'h00;
    r[5] = 8'h00;
    r[4] = neg ? 8'h40 : 8'h00;
    p = 1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0 && mag < p) r[i] = 8'h00;
      else                  r[i] = dig_glyph((mag / p) % 10);
      p = p * 10;
    end
    return {r[7], r[6], r[5], r[4], r[3], r[2], r[1], r[0]};
  endfunction

  function automatic logic [15:0] rand_bcd();
    logic [15:0] r;
    for (int i = 0; i < 4; i++) r[4*i +: 4] = 4'($urandom_range(0, 9));
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @cycle %0d: got %h, expected %h", name, cyc, act, req);
    end
  endtask

  task automatic push(input int unsigned at);
    exp_t e;
    e.segs = model(m_sel, m_val[m_sel]);
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_vals(input logic [15:0] a, v, f, t);
    alt = a; vel = v; fuel = f; thrust = t;
    m_val[0] = a; m_val[1] = v; m_val[2] = f; m_val[3] = t;
  endtask

  // Monitor: a falling busy outside reset is a commit.
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n && busy_prev && !busy) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_commit @cycle %0d: got %h, expected no commit", cyc,
                 {ss7, ss6, ss5, ss4, ss3, ss2, ss1, ss0});
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("commit_segs", {ss7, ss6, ss5, ss4, ss3, ss2, ss1, ss0}, e.segs);
        check("commit_cycle", 64'(cyc), 64'(e.at));
      end
    end
    busy_prev <= busy;
  end

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 60) begin
      @(negedge clk);
      t++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d commits outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    tick(4);
  endtask

  task automatic press(input logic [3:0] mask);
    int unsigned n;
    int s, old;
    s   = mask[3] ? 0 : mask[2] ? 1 : mask[1] ? 2 : 3;
    old = m_sel;
    n   = cyc;
    sel_pb = mask;
    m_sel  = s;
    push(n + 9);
    tick(2);
    check("sel_before", 64'(sel), 64'(old));
    tick(1);
    check("sel_after", 64'(sel), 64'(s));
    tick(1);
    sel_pb = 4'b0000;
    wait_drain();
  endtask

  task automatic write_vals(input logic [15:0] a, v, f, t);
    set_vals(a, v, f, t);
    wen = 1'b1;
    push(cyc + 7);
    tick(1);
    wen = 1'b0;
    wait_drain();
  endtask

  task automatic reset_outputs_check(input string tag);
    check({tag, "_segs"}, {ss7, ss6, ss5, ss4, ss3, ss2, ss1, ss0}, 64'h0);
    check({tag, "_busy"}, 64'(busy), 64'h0);
    check({tag, "_sel"},  64'(sel),  64'h0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    set_vals(16'h4500, 16'h0000, 16'h0000, 16'h0000);
    @(negedge clk);
    tick(3);
    reset_outputs_check("reset");
    n = cyc;
    rst_n = 1'b1;
    m_sel = 0;
    push(n + 6);
    wait_drain();

    // Negative velocity -10
    set_vals(alt, 16'h9990, fuel, thrust);
    press(4'b0100);

    // Fuel 8, then fuel 0 via a write
    set_vals(alt, vel, 16'h0008, thrust);
    press(4'b0010);
    write_vals(alt, vel, 16'h0000, thrust);

    // Simultaneous Z and W: ALT wins, one capture
    press(4'b1001);

    // Sign boundary and zero velocity
    set_vals(alt, 16'h5000, fuel, thrust);
    press(4'b0100);
    write_vals(alt, 16'h0000, fuel, thrust);

    // A write during conversion queues exactly one follow-up conversion
    n = cyc;
    set_vals(alt, 16'h0010, fuel, thrust);
    wen = 1'b1;
    push(n + 7);
    tick(1);
    wen = 1'b0;
    tick(2);
    set_vals(alt, 16'h0005, fuel, thrust);
    wen = 1'b1;
    push(n + 13);
    tick(1);
    wen = 1'b0;
    tick(2);
    check("busy_before_gap", 64'(busy), 64'h1);
    tick(1);
    check("busy_gap", 64'(busy), 64'h0);
    tick(1);
    check("busy_resume", 64'(busy), 64'h1);
    wait_drain();

    // Reset in the middle of a conversion aborts it
    set_vals(16'h0321, 16'h1234, fuel, thrust);
    wen = 1'b1;
    tick(1);
    wen = 1'b0;
    tick(2);
    rst_n = 1'b0;
    tick(1);
    reset_outputs_check("abort");
    tick(1);
    n = cyc;
    rst_n = 1'b1;
    m_sel = 0;
    push(n + 6);
    wait_drain();

    // Random presses and writes
    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 0) begin
        press(4'($urandom_range(1, 15)));
      end else begin
        write_vals(rand_bcd(), rand_bcd(), rand_bcd(), rand_bcd());
      end
    end

    tick(10);
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ll_display.md
Name: ll_display

Overview:
- Read-side consumer of the lander state registers. It samples alt/vel/fuel/thrust after each memory write or display-select press, and converts the chosen quantity to sign plus magnitude.
- It then drives the eight seven-segment digits: glyph, minus sign, and four leading-zero-blanked BCD digits.
- Sits between the lander memory/pushbutton inputs and the top-level ss7..ss0 outputs. All outputs are registered, and a conversion is never shown half-done.

Parameters:
- SYNC_STAGES, 2, number of synchroniser flops on the raw pushbuttons (minimum 2).
- SEL_RESET, 0, quantity shown after reset (0=ALT, 1=VEL, 2=FUEL, 3=THRUST).

Ports:
- clk  input  1  system clock (100 Hz in the lander build).
- rst_n  input  1  reset, synchronous, active-low.
- wen  input  1  memory write strobe; the state registers hold the new values after the edge where wen=1.
- alt  input  16  4-digit BCD altitude, unsigned.
- vel  input  16  4-digit BCD velocity, 10's complement signed.
- fuel  input  16  4-digit BCD fuel, unsigned.
- thrust  input  16  4-digit BCD thrust, unsigned.
- sel_pb  input  4  raw asynchronous buttons {Z,Y,X,W} = {ALT,VEL,FUEL,THRUST}.
- busy  output  1  conversion in progress.
- sel  output  2  quantity currently shown.
- ss7  output  8  quantity glyph.
- ss6..ss5  output  8 each  always 0.
- ss4  output  8  minus sign.
- ss3..ss0  output  8 each  magnitude digits, most significant first.

Behaviour:
- Reset (rst_n=0 at an edge) sets the following, aborting any conversion:
  - ss7..ss0=0, busy=0, sel=SEL_RESET.
  - Synchroniser flops cleared, FSM=IDLE.
  - pending=1, so the first display appears without a press.
- Input sync:
  - sel_pb passes through SYNC_STAGES flops, then one history flop; rising edge = sync & ~hist.
  - A rising edge updates sel and sets pending.
  - Simultaneous edges: priority Z>Y>X>W.
  - Pressing the already-selected button still sets pending.
- Trigger:
  - pending is set by wen=1, any button edge, or reset.
  - pending is cleared only by a capture; a trigger in the same cycle as a capture keeps it set.
- FSM states: IDLE, CONV, COMMIT.
- IDLE with pending=1:
  - Capture the selected source into work[15:0] and latch its sel into shown_sel.
  - neg = (shown_sel==VEL) && work[15:12]>=5.
  - Set busy=1 and go to CONV with digit index d=0.
- CONV, one BCD digit per cycle, LSD first, over exactly 4 cycles with d=0..3:
  - If neg: digit_d = 9's complement of digit_d plus carry, carry_in=1 at d=0, decimal carry out to the next digit.
  - Else: the digit passes through unchanged.
  - After d=3, go to COMMIT.
- COMMIT, one cycle, writes all outputs atomically, then goes to IDLE with busy=0:
  - ss7 glyph by shown_sel: ALT=8'h77 'A', VEL=8'h3E 'U', FUEL=8'h71 'F', THRUST=8'h78 't'.
  - ss4 = 8'h40 if neg else 0.
  - Leading-zero blanking: a digit is blanked (0) while it and all higher digits are 0; ss0 is never blanked.
  - Digit glyphs (bit7=0): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=67.
- Latency:
  - Capture on edge k; outputs change on edge k+5.
  - wen at edge w gives capture at w+1 and outputs at w+6.
  - Button: with SYNC_STAGES=2, sel changes 3 edges after the raw rise, and outputs change 6 edges after that.
- Triggers during CONV/COMMIT set pending only. The next capture is in the IDLE cycle right after COMMIT, and outputs keep old values until that conversion commits.
- Arithmetic boundaries:
  - vel=16'h5000 gives neg=1, magnitude 5000.
  - vel=0 gives neg=0, displays "0".
  - Non-BCD input digits are unspecified and not checked.
- wen has no effect on sel.

Decomposition:
- Package ll_disp_pkg:
  - sel_e enum (ALT, VEL, FUEL, THRUST).
  - state_e enum (IDLE, CONV, COMMIT).
  - Glyph constants GLYPH_A/U/F/T, GLYPH_MINUS, digit glyph table.
  - DISP_LATENCY=5.
- Sub-module ll_pb_sync: parameterised synchroniser plus rising-edge detect, 4 bits wide.
- BCD digit negation is an inline function in the package; no separate adder instance.

Test Plan:
- Reset, then release with alt=16'h4500: outputs all 0 during reset. Edge 5 after release: ss7=77, ss3=66, ss2=6D, ss1=3F, ss0=3F, ss4=0.
- vel=16'h9990, press Y: sel=1 after 3 edges. 6 edges later: ss7=3E, ss4=40, ss3=0, ss2=0, ss1=06, ss0=3F (shows -10).
- fuel=16'h0008, press X: ss3..ss1=0, ss0=7F. Set fuel=0 and pulse wen: ss0=3F, others blank.
- Z and W rise in the same cycle: sel=ALT, single capture, ss7=77.
- wen pulse during CONV cycle 2, with vel changed 0010→0005 while VEL is shown:
  - First commit shows 10 (ss1=06, ss0=3F).
  - Second commit follows 1 edge later, finishing at 11 edges total, showing 5.
  - busy stays high except for one IDLE cycle.
- rst_n low during CONV: next edge ss*=0, busy=0, sel=SEL_RESET. Display reappears 5 edges after release.
